// File: rtl/acc_datapath.sv
// Accumulator datapath: ACC register, Z/N status flags, add/subtract ALU,
// operand sign/zero extension and ACC source multiplexing.
module acc_datapath #(
    parameter int DATA_WIDTH    = 11,
    parameter int OPERAND_WIDTH = 11
) (
    input  logic                     clock_in,
    input  logic                     reset_in,
    input  logic [OPERAND_WIDTH-1:0] operand_in,
    input  logic [DATA_WIDTH-1:0]    data_memory_in,
    input  logic                     alu_op_in,
    input  logic [1:0]               sel_A_in,
    input  logic                     sel_B_in,
    input  logic                     acc_wr_in,
    input  logic                     acc_reset_in,
    input  logic                     status_wr_in,
    input  logic                     status_reset_in,
    output logic [DATA_WIDTH-1:0]    data_out,
    output logic [DATA_WIDTH-1:0]    ext_out,
    output logic [DATA_WIDTH-1:0]    data_memory_address_out,
    output logic                     flag_Z_out,
    output logic                     flag_N_out
);

    logic [DATA_WIDTH-1:0] acc_r;
    logic                  flag_z_r;
    logic                  flag_n_r;
    logic [DATA_WIDTH-1:0] ext_s;
    logic [DATA_WIDTH-1:0] addr_s;
    logic [DATA_WIDTH-1:0] operand_b_s;
    logic [DATA_WIDTH-1:0] alu_result_s;
    logic [DATA_WIDTH-1:0] acc_next_s;
    logic                  alu_zero_s;
    logic                  alu_neg_s;

    // Sign/zero extension; a size cast of a signed value replicates its MSB,
    // and degenerates to pass-through when both widths match.
    always_comb begin
        ext_s  = DATA_WIDTH'($signed(operand_in));
        addr_s = DATA_WIDTH'(operand_in);
    end

    // ALU operand B select and add/subtract (wraps modulo 2^DATA_WIDTH)
    always_comb begin
        operand_b_s = data_memory_in;
        if (sel_B_in) begin
            operand_b_s = ext_s;
        end else begin
            operand_b_s = data_memory_in;
        end

        alu_result_s = acc_r + operand_b_s;
        if (alu_op_in) begin
            alu_result_s = acc_r - operand_b_s;
        end else begin
            alu_result_s = acc_r + operand_b_s;
        end

        alu_zero_s = (alu_result_s == {DATA_WIDTH{1'b0}});
        alu_neg_s  = alu_result_s[DATA_WIDTH-1];
    end

    // ACC source mux; select 11 recirculates ACC so a write there is a no-op
    always_comb begin
        acc_next_s = acc_r;
        case (sel_A_in)
            2'b00:   acc_next_s = data_memory_in;
            2'b01:   acc_next_s = ext_s;
            2'b10:   acc_next_s = alu_result_s;
            2'b11:   acc_next_s = acc_r;
            default: acc_next_s = acc_r;
        endcase
    end

    // ACC register: reset, then clear strobe, then write enable
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            acc_r <= {DATA_WIDTH{1'b0}};
        end else if (acc_reset_in) begin
            acc_r <= {DATA_WIDTH{1'b0}};
        end else if (acc_wr_in) begin
            acc_r <= acc_next_s;
        end else begin
            acc_r <= acc_r;
        end
    end

    // Status flags: taken from the ALU result formed with the pre-edge ACC
    always_ff @(posedge clock_in) begin
        if (!reset_in) begin
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
        end else if (status_reset_in) begin
            flag_z_r <= 1'b0;
            flag_n_r <= 1'b0;
        end else if (status_wr_in) begin
            flag_z_r <= alu_zero_s;
            flag_n_r <= alu_neg_s;
        end else begin
            flag_z_r <= flag_z_r;
            flag_n_r <= flag_n_r;
        end
    end

    assign data_out                = acc_r;
    assign flag_Z_out              = flag_z_r;
    assign flag_N_out              = flag_n_r;
    assign ext_out                 = ext_s;
    assign data_memory_address_out = addr_s;

endmodule

// File: tb/tb_acc_datapath.sv
// Directed self-checking bench for acc_datapath with an 8-bit operand
// field on an 11-bit datapath, so sign extension is exercised.
module tb_acc_datapath;

    localparam int DW = 11;
    localparam int OW = 8;

    logic          clock_in = 1'b0;
    logic          reset_in;
    logic [OW-1:0] operand_in;
    logic [DW-1:0] data_memory_in;
    logic          alu_op_in;
    logic [1:0]    sel_A_in;
    logic          sel_B_in;
    logic          acc_wr_in;
    logic          acc_reset_in;
    logic          status_wr_in;
    logic          status_reset_in;
    logic [DW-1:0] data_out;
    logic [DW-1:0] ext_out;
    logic [DW-1:0] data_memory_address_out;
    logic          flag_Z_out;
    logic          flag_N_out;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    acc_datapath #(.DATA_WIDTH(DW), .OPERAND_WIDTH(OW)) dut (
        .clock_in                (clock_in),
        .reset_in                (reset_in),
        .operand_in              (operand_in),
        .data_memory_in          (data_memory_in),
        .alu_op_in               (alu_op_in),
        .sel_A_in                (sel_A_in),
        .sel_B_in                (sel_B_in),
        .acc_wr_in               (acc_wr_in),
        .acc_reset_in            (acc_reset_in),
        .status_wr_in            (status_wr_in),
        .status_reset_in         (status_reset_in),
        .data_out                (data_out),
        .ext_out                 (ext_out),
        .data_memory_address_out (data_memory_address_out),
        .flag_Z_out              (flag_Z_out),
        .flag_N_out              (flag_N_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic check_val(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp_val);
        chk_cnt++;
        if (obs === exp_val) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp_val);
        end
    endtask

    task automatic check_flags(input string tag, input logic z, input logic n);
        check_val({tag, "_z"}, {{(DW-1){1'b0}}, flag_Z_out}, {{(DW-1){1'b0}}, z});
        check_val({tag, "_n"}, {{(DW-1){1'b0}}, flag_N_out}, {{(DW-1){1'b0}}, n});
    endtask

    // One rising edge, then settle before sampling
    task automatic step();
        @(posedge clock_in);
        #1;
    endtask

    initial begin
        // Reset overrides write strobes
        reset_in = 1'b0; operand_in = 8'h00; data_memory_in = 11'h123;
        alu_op_in = 1'b0; sel_A_in = 2'b00; sel_B_in = 1'b0;
        acc_wr_in = 1'b1; acc_reset_in = 1'b0;
        status_wr_in = 1'b1; status_reset_in = 1'b0;
        step();
        check_val("rst_acc", data_out, 11'h000);
        check_flags("rst", 1'b0, 1'b0);

        // Load from memory, then hold with write disabled
        reset_in = 1'b1; status_wr_in = 1'b0;
        data_memory_in = 11'h001; sel_A_in = 2'b00; acc_wr_in = 1'b1;
        step();
        check_val("load_mem", data_out, 11'h001);
        acc_wr_in = 1'b0; data_memory_in = 11'h555; sel_A_in = 2'b01; operand_in = 8'h12;
        step();
        check_val("hold_acc", data_out, 11'h001);
        check_flags("hold", 1'b0, 1'b0);

        // 1 - 1 sets Z; ACC unchanged until written
        data_memory_in = 11'h001; sel_B_in = 1'b0; alu_op_in = 1'b1; status_wr_in = 1'b1;
        step();
        check_flags("sub_zero", 1'b1, 1'b0);
        check_val("sub_zero_acc", data_out, 11'h001);
        status_wr_in = 1'b0; sel_A_in = 2'b10; acc_wr_in = 1'b1;
        step();
        check_val("sub_zero_wr", data_out, 11'h000);
        check_flags("sub_zero_hold", 1'b1, 1'b0);

        // 0 - 1 wraps; flags and ACC from the same ALU result
        status_wr_in = 1'b1;
        step();
        check_val("wrap_acc", data_out, 11'h7FF);
        check_flags("wrap", 1'b0, 1'b1);

        // Extension outputs are combinational
        status_wr_in = 1'b0; acc_wr_in = 1'b0;
        operand_in = 8'hFE;
        #1;
        check_val("ext_fe", ext_out, 11'h7FE);
        check_val("addr_fe", data_memory_address_out, 11'h0FE);
        operand_in = 8'h7F;
        #1;
        check_val("ext_7f", ext_out, 11'h07F);
        check_val("addr_7f", data_memory_address_out, 11'h07F);

        // 5 + sext(FE) = 3
        operand_in = 8'hFE; sel_A_in = 2'b00; data_memory_in = 11'h005; acc_wr_in = 1'b1;
        step();
        check_val("load5", data_out, 11'h005);
        sel_B_in = 1'b1; alu_op_in = 1'b0; sel_A_in = 2'b10;
        step();
        check_val("imm_add", data_out, 11'h003);
        check_flags("imm_add_hold", 1'b0, 1'b1);

        // Load ext directly, then subtract same immediate into flags only
        operand_in = 8'h80; sel_A_in = 2'b01;
        step();
        check_val("load_ext", data_out, 11'h780);
        acc_wr_in = 1'b0; sel_B_in = 1'b1; alu_op_in = 1'b1; status_wr_in = 1'b1;
        step();
        check_flags("sub_imm", 1'b1, 1'b0);
        check_val("sub_imm_acc", data_out, 11'h780);

        // acc_reset beats acc_wr
        status_wr_in = 1'b0; acc_reset_in = 1'b1; acc_wr_in = 1'b1;
        sel_A_in = 2'b00; data_memory_in = 11'h3FF;
        step();
        check_val("acc_clr", data_out, 11'h000);
        check_flags("acc_clr_flags", 1'b1, 1'b0);

        // status_reset beats status_wr (0 - 1 would set N)
        acc_reset_in = 1'b0; acc_wr_in = 1'b0;
        sel_B_in = 1'b0; alu_op_in = 1'b1; data_memory_in = 11'h001;
        status_reset_in = 1'b1; status_wr_in = 1'b1;
        step();
        check_flags("stat_clr", 1'b0, 1'b0);

        // sel_A = 11 holds ACC while flags still update from ALU
        status_reset_in = 1'b0; status_wr_in = 1'b0;
        sel_A_in = 2'b00; data_memory_in = 11'h2AA; acc_wr_in = 1'b1;
        step();
        check_val("load_2aa", data_out, 11'h2AA);
        sel_A_in = 2'b11; data_memory_in = 11'h500; alu_op_in = 1'b0; status_wr_in = 1'b1;
        step();
        check_val("sel11_hold", data_out, 11'h2AA);
        check_flags("sel11_flags", 1'b0, 1'b1);

        // Mid-operation reset overrides pending writes
        reset_in = 1'b0; sel_A_in = 2'b00; data_memory_in = 11'h005;
        step();
        check_val("mid_rst_acc", data_out, 11'h000);
        check_flags("mid_rst", 1'b0, 1'b0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/acc_datapath.md
Name: acc_datapath

Overview:
- Accumulator-based datapath for the small processor core.
- Holds the accumulator (ACC) and the Z/N status flags, and contains a two-operation ALU (add/subtract) plus operand/data source multiplexing.
- Driven cycle by cycle by the control unit's select and write strobes.
- Feeds data memory with address and write data, and feeds the control unit with flags.

Parameters:
- DATA_WIDTH, 11, width of ACC, ALU, data memory word and all data ports.
- OPERAND_WIDTH, 11, width of the instruction operand field; must be <= DATA_WIDTH.

Ports:
- clock_in  input  1  system clock; all state updates on rising edge.
- reset_in  input  1  synchronous active-low reset; clears ACC and flags.
- operand_in  input  OPERAND_WIDTH  instruction operand (immediate / memory address).
- data_memory_in  input  DATA_WIDTH  word read from data memory.
- alu_op_in  input  1  ALU function: 0 = add, 1 = subtract.
- sel_A_in  input  2  ACC write source select.
- sel_B_in  input  1  ALU operand B select.
- acc_wr_in  input  1  ACC write enable.
- acc_reset_in  input  1  synchronous active-high ACC clear strobe.
- status_wr_in  input  1  status flag write enable.
- status_reset_in  input  1  synchronous active-high flag clear strobe.
- data_out  output  DATA_WIDTH  current ACC value (memory write data).
- ext_out  output  DATA_WIDTH  operand_in sign-extended to DATA_WIDTH.
- data_memory_address_out  output  DATA_WIDTH  operand_in zero-extended to DATA_WIDTH.
- flag_Z_out  output  1  registered zero flag.
- flag_N_out  output  1  registered negative flag.

Behaviour:
- One clock, clock_in; reset is synchronous and active-low (reset_in).
- State:
  - ACC register, DATA_WIDTH bits.
  - Z and N flag registers.
  - All other logic is combinational.
- Reset values:
  - reset_in = 0 at a rising edge: ACC = 0, Z = 0, N = 0.
  - Hence data_out = 0 and both flags = 0.
- ALU operand A is always ACC.
- ALU operand B:
  - sel_B_in = 0: data_memory_in.
  - sel_B_in = 1: ext_out.
- ALU result (combinational, DATA_WIDTH bits, two's complement, wraps modulo 2^DATA_WIDTH):
  - alu_op_in = 0: A + B.
  - alu_op_in = 1: A - B.
  - No carry or overflow output.
- ACC source mux (sel_A_in):
  - 00: data_memory_in.
  - 01: ext_out.
  - 10: ALU result.
  - 11: ACC holds its current value (no change even if acc_wr_in = 1).
- ACC update priority per rising edge:
  1. reset_in = 0: ACC = 0.
  2. acc_reset_in = 1: ACC = 0.
  3. acc_wr_in = 1: ACC = mux value.
  4. Otherwise hold.
- Flag update priority per rising edge:
  1. reset_in = 0: flags = 0.
  2. status_reset_in = 1: flags = 0.
  3. status_wr_in = 1: Z = (ALU result == 0), N = ALU result[DATA_WIDTH-1].
  4. Otherwise hold.
- Flags always come from the ALU result, independent of sel_A_in.
- Flags are sampled from the pre-edge ACC value; acc_wr_in and status_wr_in asserted in the same cycle update both registers from the same ALU result.
- Latency:
  - ACC and flags change one edge after the strobe.
  - data_out, flag_Z_out and flag_N_out are register outputs.
  - ext_out and data_memory_address_out are purely combinational from operand_in, zero latency.
- Extension:
  - ext_out = {(DATA_WIDTH-OPERAND_WIDTH){operand_in[MSB]}, operand_in}.
  - data_memory_address_out = zero-extended operand_in.
  - When OPERAND_WIDTH = DATA_WIDTH, both are plain pass-through.
- Uninitialised controls (X) outside reset: no requirement; controls are driven by the control unit.
- Reset asserted mid-operation overrides any pending write in the same cycle.

Test Plan:
- Reset: reset_in = 0 for 1 edge with acc_wr_in = 1, status_wr_in = 1 -> data_out = 0, Z = 0, N = 0.
- Load memory: sel_A = 00, data_memory_in = 1, acc_wr 1 edge -> data_out = 1; with acc_wr = 0 and other inputs changing, ACC holds 1.
- Subtract to zero: ACC = 1, data_memory_in = 1, sel_B = 0, alu_op = 1, status_wr 1 edge -> Z = 1, N = 0; then sel_A = 10, acc_wr 1 edge -> data_out = 0.
- Negative/wrap: ACC = 0, subtract data_memory_in = 1 with status_wr and acc_wr (sel_A = 10) in the same cycle -> data_out = 11'h7FF, N = 1, Z = 0.
- Immediate add: OPERAND_WIDTH = 8, DATA_WIDTH = 11, operand_in = 8'hFE -> ext_out = 11'h7FE, data_memory_address_out = 11'h0FE; ACC = 5, sel_B = 1, alu_op = 0, sel_A = 10, acc_wr -> data_out = 3.
- Clears/priority:
  - acc_reset_in = 1 with acc_wr_in = 1 -> ACC = 0.
  - status_reset_in = 1 with status_wr_in = 1 -> flags 0.
  - sel_A = 11 with acc_wr -> ACC unchanged.
